// File: rtl/controller.sv
// Single-cycle ARM-subset control unit: decode, condition check, NZCV flags
// and a counter of retired instructions.
module controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             CO,
  input  logic             OVF,
  input  logic             N,
  input  logic             Z,
  output logic             PCSrc,
  output logic [1:0]       RegSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       shft_ctrl,
  output logic [4:0]       shamt_ctrl,
  output logic             carry_in,
  output logic [3:0]       ALUControl,
  output logic [1:0]       mux_mine,
  output logic             bx_mux,
  output logic [3:0]       flags,
  output logic             cond_pass,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_DP,
    CLS_MEM,
    CLS_BR,
    CLS_BX
  } cls_t;

  cls_t       cls;
  logic [3:0] cmd;
  logic       is_arith;
  logic       flag_we;
  logic       fn, fz, fc, fv;

  assign cmd = inst[24:21];
  assign {fn, fz, fc, fv} = flags;
  assign carry_in = fc;

  // BX lives inside the DP encoding space and must be matched first.
  always_comb begin
    cls = CLS_NOP;
    if (inst[27:4] == 24'h12FFF1) begin
      cls = CLS_BX;
    end else begin
      case (inst[27:26])
        2'b00:   cls = (!inst[25] && inst[4]) ? CLS_NOP : CLS_DP;
        2'b01:   cls = inst[25] ? CLS_NOP : CLS_MEM;
        2'b10:   cls = CLS_BR;
        default: cls = CLS_NOP;
      endcase
    end
  end

  always_comb begin
    cond_pass = 1'b0;
    case (inst[31:28])
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = !fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = !fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = !fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = !fv;
      4'b1000: cond_pass = fc && !fz;
      4'b1001: cond_pass = !fc || fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = !fz && (fn == fv);
      4'b1101: cond_pass = fz || (fn != fv);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    is_arith = 1'b0;
    case (cmd)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: is_arith = 1'b1;
      default:                            is_arith = 1'b0;
    endcase
  end

  always_comb begin
    PCSrc      = 1'b0;
    RegSrc     = 2'b00;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    ImmSrc     = 2'b00;
    shft_ctrl  = 2'b00;
    shamt_ctrl = '0;
    ALUControl = 4'b0000;
    mux_mine   = 2'b00;
    bx_mux     = 1'b0;
    case (cls)
      CLS_DP: begin
        ALUControl = cmd;
        RegWrite   = !(cmd inside {4'b1000, 4'b1001, 4'b1010, 4'b1011});
        PCSrc      = RegWrite && (inst[15:12] == 4'hF);
        if (inst[25]) begin
          ALUSrc     = 1'b1;
          ImmSrc     = 2'b00;
          shft_ctrl  = 2'b11;
          shamt_ctrl = {inst[11:8], 1'b0};
        end else begin
          shft_ctrl  = inst[6:5];
          shamt_ctrl = inst[11:7];
        end
      end
      CLS_MEM: begin
        ALUSrc     = 1'b1;
        ImmSrc     = 2'b01;
        ALUControl = inst[23] ? 4'b0100 : 4'b0010;
        if (inst[20]) begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          PCSrc    = (inst[15:12] == 4'hF);
        end else begin
          MemWrite = 1'b1;
          RegSrc   = 2'b10;
        end
      end
      CLS_BR: begin
        RegSrc     = 2'b01;
        ALUSrc     = 1'b1;
        ImmSrc     = 2'b10;
        ALUControl = 4'b0100;
        PCSrc      = 1'b1;
        if (inst[24]) begin
          RegWrite = 1'b1;
          mux_mine = 2'b11;
        end
      end
      CLS_BX: begin
        bx_mux     = 1'b1;
        ALUControl = 4'b1101;
        PCSrc      = 1'b1;
      end
      default: ;
    endcase
    // A failed condition suppresses only architectural side effects.
    if (!cond_pass) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCSrc    = 1'b0;
    end
  end

  assign flag_we = cond_pass && (cls == CLS_DP) && inst[20];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      flags   <= '0;
      retired <= '0;
    end else begin
      if (flag_we) begin
        flags[3] <= N;
        flags[2] <= Z;
        if (is_arith) flags[1:0] <= {CO, OVF};
      end
      if (cond_pass && (cls != CLS_NOP)) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: decode per class, condition gating, flag
// update rules, asynchronous reset and counter wrap (counter narrowed to 4 bits).
module tb_controller;

  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic [31:0]   inst;
  logic          CO, OVF, N, Z;
  logic          PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, carry_in, bx_mux, cond_pass;
  logic [1:0]    RegSrc, ImmSrc, shft_ctrl, mux_mine;
  logic [4:0]    shamt_ctrl;
  logic [3:0]    ALUControl, flags;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  controller #(.CNT_W(CW)) dut (
    .clock(clock), .rst(rst), .inst(inst), .CO(CO), .OVF(OVF), .N(N), .Z(Z),
    .PCSrc(PCSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .shft_ctrl(shft_ctrl),
    .shamt_ctrl(shamt_ctrl), .carry_in(carry_in), .ALUControl(ALUControl),
    .mux_mine(mux_mine), .bx_mux(bx_mux), .flags(flags), .cond_pass(cond_pass),
    .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic n, input logic z, input logic c, input logic v);
    N = n; Z = z; CO = c; OVF = v;
  endtask

  initial begin
    rst = 1'b1; inst = 32'hE1A00000; alu(0, 0, 0, 0);
    #12 rst = 1'b0;
    #1;
    chk("rst_flags",   32'(flags),   32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_carry",   32'(carry_in), 32'h0);

    // ADDS r0,r1,r2 : arithmetic, all of NZCV load
    inst = 32'hE0910002; alu(1, 0, 0, 1); #1;
    chk("adds_regwrite", 32'(RegWrite), 32'h1);
    chk("adds_alu",      32'(ALUControl), 32'h4);
    chk("adds_alusrc",   32'(ALUSrc), 32'h0);
    chk("adds_pcsrc",    32'(PCSrc), 32'h0);
    tick();
    chk("adds_flags",   32'(flags),   32'h9);
    chk("adds_retired", 32'(retired), 32'h1);

    // ANDS : logical, C and V hold
    inst = 32'hE0110002; alu(0, 1, 1, 0); #1;
    chk("ands_alu", 32'(ALUControl), 32'h0);
    tick();
    chk("ands_flags", 32'(flags), 32'h5);

    // CMP r0,r1 : no register write, C/V load
    inst = 32'hE1500001; alu(0, 1, 1, 0); #1;
    chk("cmp_regwrite", 32'(RegWrite), 32'h0);
    chk("cmp_alu",      32'(ALUControl), 32'hA);
    tick();
    chk("cmp_flags", 32'(flags),    32'h6);
    chk("cmp_carry", 32'(carry_in), 32'h1);
    chk("cmp_retired", 32'(retired), 32'h3);

    // BEQ : passes on Z=1; branches never touch flags
    inst = 32'h0A000002; alu(1, 0, 0, 1); #1;
    chk("beq_pass",   32'(cond_pass), 32'h1);
    chk("beq_pcsrc",  32'(PCSrc),  32'h1);
    chk("beq_immsrc", 32'(ImmSrc), 32'h2);
    chk("beq_regsrc", 32'(RegSrc), 32'h1);
    chk("beq_alusrc", 32'(ALUSrc), 32'h1);
    chk("beq_alu",    32'(ALUControl), 32'h4);
    chk("beq_regwrite", 32'(RegWrite), 32'h0);
    tick();
    chk("beq_retired", 32'(retired), 32'h4);
    chk("beq_flags",   32'(flags),   32'h6);

    // BNE : fails, selects still decoded
    inst = 32'h1A000002; #1;
    chk("bne_pass",   32'(cond_pass), 32'h0);
    chk("bne_pcsrc",  32'(PCSrc),  32'h0);
    chk("bne_immsrc", 32'(ImmSrc), 32'h2);
    tick();
    chk("bne_retired", 32'(retired), 32'h4);

    // BL
    inst = 32'hEB000010; #1;
    chk("bl_muxmine",  32'(mux_mine), 32'h3);
    chk("bl_regwrite", 32'(RegWrite), 32'h1);
    chk("bl_pcsrc",    32'(PCSrc),    32'h1);
    tick();
    chk("bl_retired", 32'(retired), 32'h5);

    // BX LR
    inst = 32'hE12FFF1E; #1;
    chk("bx_bxmux",    32'(bx_mux), 32'h1);
    chk("bx_alu",      32'(ALUControl), 32'hD);
    chk("bx_alusrc",   32'(ALUSrc), 32'h0);
    chk("bx_pcsrc",    32'(PCSrc),  32'h1);
    chk("bx_regwrite", 32'(RegWrite), 32'h0);
    tick();
    chk("bx_retired", 32'(retired), 32'h6);

    // STR r1,[r2,#4]
    inst = 32'hE5821004; #1;
    chk("str_memwrite", 32'(MemWrite), 32'h1);
    chk("str_regsrc",   32'(RegSrc),   32'h2);
    chk("str_alu",      32'(ALUControl), 32'h4);
    chk("str_immsrc",   32'(ImmSrc),   32'h1);
    chk("str_regwrite", 32'(RegWrite), 32'h0);
    tick();

    // LDR r1,[r2,#-4]
    inst = 32'hE5121004; #1;
    chk("ldr_memtoreg", 32'(MemtoReg), 32'h1);
    chk("ldr_regwrite", 32'(RegWrite), 32'h1);
    chk("ldr_alu",      32'(ALUControl), 32'h2);
    chk("ldr_memwrite", 32'(MemWrite), 32'h0);
    chk("ldr_pcsrc",    32'(PCSrc),    32'h0);
    tick();
    chk("ldr_retired", 32'(retired), 32'h8);

    // MOV pc,#imm (rot=1) : immediate operand, write to R15
    inst = 32'hE3A0F102; #1;
    chk("movi_alusrc", 32'(ALUSrc), 32'h1);
    chk("movi_immsrc", 32'(ImmSrc), 32'h0);
    chk("movi_shft",   32'(shft_ctrl), 32'h3);
    chk("movi_shamt",  32'(shamt_ctrl), 32'h2);
    chk("movi_pcsrc",  32'(PCSrc), 32'h1);
    tick();

    // MOV r1,r2,ASR #2
    inst = 32'hE1A01142; #1;
    chk("movr_shft",   32'(shft_ctrl), 32'h2);
    chk("movr_shamt",  32'(shamt_ctrl), 32'h2);
    chk("movr_alusrc", 32'(ALUSrc), 32'h0);
    tick();
    chk("movr_retired", 32'(retired), 32'hA);

    // Unsupported encodings and cond=1111: no effects, nothing retired
    alu(1, 1, 0, 1);
    inst = 32'hEE000000; #1;
    chk("cls11_regwrite", 32'(RegWrite), 32'h0);
    chk("cls11_pcsrc",    32'(PCSrc),    32'h0);
    tick();
    inst = 32'hE0910312; #1;
    chk("rsr_regwrite", 32'(RegWrite), 32'h0);
    tick();
    inst = 32'hE7921003; #1;
    chk("memreg_regwrite", 32'(RegWrite), 32'h0);
    tick();
    inst = 32'hF0910002; #1;
    chk("nv_pass",     32'(cond_pass), 32'h0);
    chk("nv_regwrite", 32'(RegWrite),  32'h0);
    tick();
    chk("nop_flags",   32'(flags),   32'h6);
    chk("nop_retired", 32'(retired), 32'hA);

    // Asynchronous reset mid-cycle
    inst = 32'h0A000002;
    #2 rst = 1'b1;
    #1;
    chk("arst_flags",   32'(flags),    32'h0);
    chk("arst_retired", 32'(retired),  32'h0);
    chk("arst_carry",   32'(carry_in), 32'h0);
    chk("arst_eq_fail", 32'(cond_pass), 32'h0);
    #1 rst = 1'b0;

    // Counter wrap with MOV r0,r0 (no S)
    inst = 32'hE1A00000;
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_full", 32'(retired), 32'hF);
    tick();
    chk("wrap_zero",  32'(retired), 32'h0);
    chk("wrap_flags", 32'(flags),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/controller.md
# controller

Control unit for the single-cycle ARM-subset `datapath`. It decodes the fetched instruction (`inst`) and drives every datapath control input. It owns the NZCV flag register and the condition check. It also keeps a retired-instruction counter. It sits directly upstream of `datapath`: `inst` and the ALU flags arrive from it, and control outputs return to it in the same cycle.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst  in  32  current instruction from instruction memory
- CO, OVF, N, Z  in  1 each  combinational ALU flags of the current instruction
- PCSrc  out  1  1 = next PC from Result
- RegSrc  out  2  [0]=1 selects R15 as RA1; [1]=1 selects inst[15:12] as RA2
- RegWrite, MemWrite, MemtoReg, ALUSrc  out  1 each  datapath enables/selects
- ImmSrc  out  2  00 imm8 zero-ext, 01 imm12 zero-ext, 10 imm24 sign-ext <<2
- shft_ctrl  out  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- shamt_ctrl  out  5  shift amount
- carry_in  out  1  registered C flag
- ALUControl  out  4  ARM cmd encoding (0000 AND … 1111 MVN)
- mux_mine  out  2  11 for BL (A3=R14, WD3=PC+4), else 00
- bx_mux  out  1  1 for BX (read port 2 = R14)
- flags  out  4  registered {N,Z,C,V}
- cond_pass  out  1  current instruction's condition holds
- retired  out  CNT_W  count of condition-passed, supported instructions

## Operation
- Condition: evaluate inst[31:28] against the registered flags (EQ…AL, standard ARM table). Code 1111 counts as fail.
- Class, selected by inst[27:26]:
  - 00 = DP.
  - 01 = LDR/STR, immediate offset only (inst[25]=0).
  - 10 = B/BL; inst[24] is L.
  - BX is exactly inst[27:4]=0x12FFF1.
  - Unsupported, executed as NOP (no writes, no PC change, not counted): class 11, DP register-shifted-register (I=0, inst[4]=1), mem with inst[25]=1.
- DP, immediate (I=1): ALUSrc=1, ImmSrc=00, shft_ctrl=11, shamt={inst[11:8],0}.
- DP, register: ALUSrc=0, shft_ctrl=inst[6:5], shamt=inst[11:7].
- DP, common: ALUControl=inst[24:21]. RegWrite=1 except TST/TEQ/CMP/CMN. PCSrc=1 if Rd=15 and RegWrite.
- Mem: ALUSrc=1, ImmSrc=01, LSL 0. ALUControl=ADD (0100) if U=inst[23] else SUB (0010).
  - LDR: RegWrite=1, MemtoReg=1; PCSrc=1 if Rd=15.
  - STR: MemWrite=1, RegSrc[1]=1.
- Branch: RegSrc[0]=1, ALUSrc=1, ImmSrc=10, ALUControl=ADD, LSL 0, PCSrc=1. BL additionally sets RegWrite=1 and mux_mine=11.
- BX: bx_mux=1, ALUSrc=0, ALUControl=MOV (1101), LSL 0, PCSrc=1. The target is always R14; Rm is ignored.
- Condition fail: force RegWrite=MemWrite=PCSrc=0. Flags and counter hold. Other selects stay as decoded.
- Flag update requires a passed condition, DP class, and S=inst[20]=1 (compares always have S=1):
  - N and Z are always loaded.
  - C and V load from CO/OVF for arithmetic cmds (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN).
  - C and V hold for logical cmds.
- carry_in = registered C.
- retired increments by 1 per passed, supported instruction and wraps from 2^CNT_W−1 to 0.

## Timing
- All control outputs and cond_pass are combinational from inst and registered flags, with zero latency.
- flags and retired update on the rising clock edge that ends the instruction.
- Flags written by instruction k are visible to the condition check of instruction k+1, never to k itself.
- Reset (asynchronous, any time): flags=0000 and retired=0 immediately.
  - Outputs then reflect the decode of inst with flags=0000; EQ, for example, fails.
  - Reset deassertion takes effect at the next edge.
- When flag update and counter increment fall on the same edge, both occur.

## Test plan
- Reset: assert rst mid-cycle -> flags=0, retired=0, carry_in=0 without a clock edge.
- ADDS (E0910002) with N=1, Z=0, CO=0, OVF=1 -> edge -> flags=1001. A following ANDS with CO=1, N=0, Z=1 -> flags=0101; C and V hold.
- CMP (E1500001) with Z=1 -> RegWrite=0, flags Z=1. Then BEQ (0A000002) -> PCSrc=1, ImmSrc=10, RegSrc=01. BNE (1A000002) -> PCSrc=0, retired unchanged.
- BL (EB000010) -> mux_mine=11, RegWrite=1, PCSrc=1. BX LR (E12FFF1E) -> bx_mux=1, ALUControl=1101, ALUSrc=0, PCSrc=1.
- STR (E5821004) -> MemWrite=1, RegSrc=10, ALUControl=0100, ImmSrc=01. LDR U=0 (E5121004) -> MemtoReg=1, RegWrite=1, ALUControl=0010.
- Unsupported (EE000000) and cond=1111 -> no writes, no flag change, retired holds. Preload retired to all-ones, then retire one -> wraps to 0.
